// File: rtl/uart_avalon_master_bridge.sv
// UART-to-Avalon-MM master bridge: 8N1 'W'/'R' byte commands in, one bus access and reply out.
// Optional waitrequest watchdog is compiled in with `define UART_BRIDGE_TIMEOUT_EN.
module uart_avalon_master_bridge #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_RXD,
  output logic        uart_TXD,
  output logic [31:0] avm_address,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic        avm_write,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  // Avalon handshake: a request (avm_read or avm_write) with address/data is held
  // constant while avm_waitrequest is high and completes on the first clock edge
  // where avm_waitrequest is low; read data is taken READ_LATENCY edges after that.

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_BUS_WR, S_BUS_RD, S_RD_WAIT, S_RESP
  } state_t;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  state_t            state;
  rx_state_t         rx_st;
  tx_state_t         tx_st;

  logic              rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0]  rx_cnt;
  logic [2:0]        rx_bits;
  logic [7:0]        rx_shift;
  logic              rx_dv;

  logic [CNT_W-1:0]  tx_cnt;
  logic [2:0]        tx_bits;
  logic [7:0]        tx_shift;
  logic              tx_req;
  logic [7:0]        tx_byte;

  logic              is_write;
  logic [1:0]        byte_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [31:0]       resp_data;
  logic [2:0]        resp_len;
  logic [2:0]        resp_idx;

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0]   to_cnt;
`endif

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // RX engine: a frame starts only on a high-to-low transition of the synchronised line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_st    <= R_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_dv    <= 1'b0;
    end else begin
      rx_meta <= uart_RXD;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      rx_dv   <= 1'b0;
      case (rx_st)
        R_IDLE: begin
          rx_cnt  <= '0;
          rx_bits <= '0;
          if (rx_prev && !rx_sync) rx_st <= R_START;
        end
        R_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_st  <= rx_sync ? R_IDLE : R_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bits == 3'd7) rx_st <= R_STOP;
            else                 rx_bits <= rx_bits + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_cnt == BIT_LAST) begin
            rx_st <= R_IDLE;
            rx_dv <= rx_sync;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_st    <= T_IDLE;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_shift <= '0;
      uart_TXD <= 1'b1;
    end else begin
      case (tx_st)
        T_IDLE: begin
          tx_cnt  <= '0;
          tx_bits <= '0;
          if (tx_req) begin
            tx_shift <= tx_byte;
            uart_TXD <= 1'b0;
            tx_st    <= T_START;
          end
        end
        T_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            uart_TXD <= tx_shift[0];
            tx_st    <= T_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        T_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bits == 3'd7) begin
              uart_TXD <= 1'b1;
              tx_st    <= T_STOP;
            end else begin
              tx_bits  <= tx_bits + 1'b1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_TXD <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          if (tx_cnt == BIT_LAST) tx_st <= T_IDLE;
          else                    tx_cnt <= tx_cnt + 1'b1;
        end
      endcase
    end
  end

  // Command FSM; received bytes are only consumed in IDLE/ADDR/DATA, so anything
  // arriving during the bus access or the reply is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      avm_address   <= '0;
      avm_writedata <= '0;
      avm_write     <= 1'b0;
      avm_read      <= 1'b0;
      is_write      <= 1'b0;
      byte_cnt      <= '0;
      lat_cnt       <= '0;
      resp_data     <= '0;
      resp_len      <= '0;
      resp_idx      <= '0;
      tx_req        <= 1'b0;
      tx_byte       <= '0;
`ifdef UART_BRIDGE_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else begin
      tx_req <= 1'b0;
      case (state)
        S_IDLE: begin
          byte_cnt <= '0;
          if (rx_dv && (rx_shift == 8'h57 || rx_shift == 8'h52)) begin
            is_write <= (rx_shift == 8'h57);
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (rx_dv) begin
            avm_address <= {rx_shift, avm_address[31:8]};
            byte_cnt    <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
`ifdef UART_BRIDGE_TIMEOUT_EN
              to_cnt <= '0;
`endif
              if (is_write) begin
                state <= S_DATA;
              end else begin
                avm_read <= 1'b1;
                state    <= S_BUS_RD;
              end
            end
          end
        end
        S_DATA: begin
          if (rx_dv) begin
            avm_writedata <= {rx_shift, avm_writedata[31:8]};
            byte_cnt      <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              avm_write <= 1'b1;
              state     <= S_BUS_WR;
            end
          end
        end
        S_BUS_WR: begin
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            resp_data <= 32'h0000_004B;
            resp_len  <= 3'd1;
            resp_idx  <= '0;
            state     <= S_RESP;
          end
`ifdef UART_BRIDGE_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            avm_write <= 1'b0;
            resp_data <= 32'h0000_00EE;
            resp_len  <= 3'd1;
            resp_idx  <= '0;
            state     <= S_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_BUS_RD: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            lat_cnt  <= '0;
            state    <= S_RD_WAIT;
          end
`ifdef UART_BRIDGE_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            avm_read  <= 1'b0;
            resp_data <= 32'h0000_00EE;
            resp_len  <= 3'd1;
            resp_idx  <= '0;
            state     <= S_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_RD_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            resp_data <= avm_readdata;
            resp_len  <= 3'd4;
            resp_idx  <= '0;
            state     <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: begin
          // tx_req is checked so a byte is never issued twice before the TX engine leaves idle.
          if (!tx_req && tx_st == T_IDLE) begin
            if (resp_idx == resp_len) begin
              state <= S_IDLE;
            end else begin
              tx_req    <= 1'b1;
              tx_byte   <= resp_data[7:0];
              resp_data <= {8'h00, resp_data[31:8]};
              resp_idx  <= resp_idx + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
